// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_START_BUSY_EN to raise busy combinationally in the launch cycle itself.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] hiloop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic        is_md, is_div, is_signed_div, is_mult;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, quo, rem;

  assign is_md         = (hiloop >= 11'd1) && (hiloop <= 11'd4);
  assign is_div        = (hiloop == 11'd1) || (hiloop == 11'd2);
  assign is_signed_div = (hiloop == 11'd1);
  assign is_mult       = (hiloop == 11'd3);

  // Signed divide runs on magnitudes through one unsigned divider, then fixes signs;
  // this also yields the 0x80000000 / -1 case (quotient wraps to 0x80000000) for free.
  always_comb begin
    prod_s  = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    prod_u  = {32'b0, rs_data} * {32'b0, rt_data};
    a_mag   = (is_signed_div && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    b_mag   = (is_signed_div && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = a_mag / divisor;
    ur      = a_mag % divisor;
    quo     = (is_signed_div && (rs_data[31] ^ rt_data[31])) ? (32'd0 - uq) : uq;
    rem     = (is_signed_div && rs_data[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state     = (cnt_q == '0) ? IDLE : RUN;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state)
      IDLE: begin
        if (start && is_md) begin
          cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          if (is_div) begin
            pend_hi_d = rem;
            pend_lo_d = quo;
            pend_wr_d = (rt_data != 32'd0);
          end else begin
            pend_hi_d = is_mult ? prod_s[63:32] : prod_u[63:32];
            pend_lo_d = is_mult ? prod_s[31:0]  : prod_u[31:0];
            pend_wr_d = 1'b1;
          end
        end else if (hiloop == 11'd5) begin
          hi_d = rs_data;
        end else if (hiloop == 11'd6) begin
          lo_d = rs_data;
        end
      end
      RUN: begin
        // Requests arriving while running, including at the retire edge, are dropped.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1) && pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

`ifdef MDU_START_BUSY_EN
  assign busy = (cnt_q != '0) | (start & is_md);
`else
  assign busy = (cnt_q != '0);
`endif

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
